// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue stage: ALU opcodes and operand-select encodings.
package cpu_consts;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    typedef enum logic {SEL_RS1 = 1'b0, SEL_PC  = 1'b1} opr_a_sel_e;
    typedef enum logic {SEL_RS2 = 1'b0, SEL_IMM = 1'b1} opr_b_sel_e;

endpackage

// File: rtl/alu_fwd_mux.sv
// Source operand resolver: x0, EX forward, WB forward, then regfile, in that priority.
// Also flags a hit on an EX result that is not yet available.
module alu_fwd_mux #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] addr_i,
    input  logic [XLEN-1:0]   rf_data_i,
    input  logic              ex_en_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [XLEN-1:0]   ex_data_i,
    input  logic              ex_pend_i,
    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic [XLEN-1:0]   data_o,
    output logic              ex_pend_hit_o
);

    logic nonzero;
    logic ex_hit;
    logic wb_hit;

    assign nonzero       = (addr_i != '0);
    assign ex_hit        = nonzero && ex_en_i && (addr_i == ex_rd_i);
    assign wb_hit        = nonzero && wb_en_i && (addr_i == wb_rd_i);
    assign ex_pend_hit_o = ex_hit && ex_pend_i;

    // NOTE: every path assigns data_o, so no latch is inferred.
    always_comb begin
        if (!nonzero)    data_o = '0;
        else if (ex_hit) data_o = ex_data_i;
        else if (wb_hit) data_o = wb_data_i;
        else             data_o = rf_data_i;
    end

endmodule

// File: rtl/alu_issue.sv
// Decode-to-execute issue stage: resolves operands, detects load-use hazards and
// holds one registered slot with valid/ready handshakes on both sides.
module alu_issue
    import cpu_consts::*;
#(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic              opr_a_sel_i,
    input  logic              opr_b_sel_i,
    input  logic [3:0]        alu_func_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              rd_wr_en_i,
    input  logic              ex_fwd_en_i,
    input  logic [REG_AW-1:0] ex_fwd_rd_i,
    input  logic [XLEN-1:0]   ex_fwd_data_i,
    input  logic              ex_fwd_pend_i,
    input  logic              wb_fwd_en_i,
    input  logic [REG_AW-1:0] wb_fwd_rd_i,
    input  logic [XLEN-1:0]   wb_fwd_data_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [XLEN-1:0]   opr_a_o,
    output logic [XLEN-1:0]   opr_b_o,
    output logic [3:0]        alu_func_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              rd_wr_en_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            rs1_pend, rs2_pend;

    alu_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .addr_i(rs1_addr_i), .rf_data_i(rs1_data_i),
        .ex_en_i(ex_fwd_en_i), .ex_rd_i(ex_fwd_rd_i), .ex_data_i(ex_fwd_data_i),
        .ex_pend_i(ex_fwd_pend_i),
        .wb_en_i(wb_fwd_en_i), .wb_rd_i(wb_fwd_rd_i), .wb_data_i(wb_fwd_data_i),
        .data_o(rs1_val), .ex_pend_hit_o(rs1_pend)
    );

    alu_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .addr_i(rs2_addr_i), .rf_data_i(rs2_data_i),
        .ex_en_i(ex_fwd_en_i), .ex_rd_i(ex_fwd_rd_i), .ex_data_i(ex_fwd_data_i),
        .ex_pend_i(ex_fwd_pend_i),
        .wb_en_i(wb_fwd_en_i), .wb_rd_i(wb_fwd_rd_i), .wb_data_i(wb_fwd_data_i),
        .data_o(rs2_val), .ex_pend_hit_o(rs2_pend)
    );

    logic              ex_valid_q,  ex_valid_d;
    logic [XLEN-1:0]   opr_a_q,     opr_a_d;
    logic [XLEN-1:0]   opr_b_q,     opr_b_d;
    logic [3:0]        alu_func_q,  alu_func_d;
    logic [REG_AW-1:0] rd_addr_q,   rd_addr_d;
    logic              rd_wr_en_q,  rd_wr_en_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic hazard, slot_free, accept;

    // Only operands actually routed from a register can wait on a pending load.
    assign hazard = ((opr_a_sel_i == SEL_RS1) && rs1_pend) ||
                    ((opr_b_sel_i == SEL_RS2) && rs2_pend);
    assign slot_free   = !ex_valid_q || ex_ready_i;
    assign dec_ready_o = slot_free && !hazard && !flush_i;
    assign accept      = dec_valid_i && dec_ready_o;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        opr_a_d     = opr_a_q;
        opr_b_d     = opr_b_q;
        alu_func_d  = alu_func_q;
        rd_addr_d   = rd_addr_q;
        rd_wr_en_d  = rd_wr_en_q;
        stall_cnt_d = stall_cnt_q;

        if (flush_i) begin
            ex_valid_d = 1'b0;
            rd_wr_en_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            opr_a_d    = (opr_a_sel_i == SEL_PC)  ? pc_i  : rs1_val;
            opr_b_d    = (opr_b_sel_i == SEL_IMM) ? imm_i : rs2_val;
            alu_func_d = alu_func_i;
            rd_addr_d  = rd_addr_i;
            rd_wr_en_d = rd_wr_en_i;
        end else if (slot_free) begin
            ex_valid_d = 1'b0;
        end

        if (dec_valid_i && !dec_ready_o && !flush_i && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_valid_q  <= 1'b0;
            opr_a_q     <= '0;
            opr_b_q     <= '0;
            alu_func_q  <= OP_ADD;
            rd_addr_q   <= '0;
            rd_wr_en_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            opr_a_q     <= opr_a_d;
            opr_b_q     <= opr_b_d;
            alu_func_q  <= alu_func_d;
            rd_addr_q   <= rd_addr_d;
            rd_wr_en_q  <= rd_wr_en_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid_o  = ex_valid_q;
    assign opr_a_o     = opr_a_q;
    assign opr_b_o     = opr_b_q;
    assign alu_func_o  = alu_func_q;
    assign rd_addr_o   = rd_addr_q;
    assign rd_wr_en_o  = rd_wr_en_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a transaction-level model predicts the slot contents,
// dec_ready_o and the stall counters; a monitor compares every cycle the DUT presents.
module tb_alu_issue;
    import cpu_consts::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        dec_valid_i, dec_ready_o;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i, ex_fwd_rd_i, wb_fwd_rd_i;
    logic [63:0] rs1_data_i, rs2_data_i, pc_i, imm_i, ex_fwd_data_i, wb_fwd_data_i;
    logic        opr_a_sel_i, opr_b_sel_i, rd_wr_en_i;
    logic [3:0]  alu_func_i;
    logic        ex_fwd_en_i, ex_fwd_pend_i, wb_fwd_en_i, flush_i, ex_ready_i;
    logic        ex_valid_o, rd_wr_en_o;
    logic [63:0] opr_a_o, opr_b_o;
    logic [3:0]  alu_func_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] stall_cnt_o;

    logic        s_dec_ready, s_ex_valid, s_rd_wr_en;
    logic [63:0] s_opr_a, s_opr_b;
    logic [3:0]  s_alu_func, s_stall_cnt;
    logic [4:0]  s_rd_addr;

    always #5 clk = ~clk;

    alu_issue #(.XLEN(64), .REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .pc_i(pc_i), .imm_i(imm_i),
        .opr_a_sel_i(opr_a_sel_i), .opr_b_sel_i(opr_b_sel_i),
        .alu_func_i(alu_func_i), .rd_addr_i(rd_addr_i), .rd_wr_en_i(rd_wr_en_i),
        .ex_fwd_en_i(ex_fwd_en_i), .ex_fwd_rd_i(ex_fwd_rd_i),
        .ex_fwd_data_i(ex_fwd_data_i), .ex_fwd_pend_i(ex_fwd_pend_i),
        .wb_fwd_en_i(wb_fwd_en_i), .wb_fwd_rd_i(wb_fwd_rd_i), .wb_fwd_data_i(wb_fwd_data_i),
        .flush_i(flush_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .opr_a_o(opr_a_o), .opr_b_o(opr_b_o), .alu_func_o(alu_func_o),
        .rd_addr_o(rd_addr_o), .rd_wr_en_o(rd_wr_en_o), .stall_cnt_o(stall_cnt_o)
    );

    // Narrow-counter build driven by the same stimulus, used for saturation checks.
    alu_issue #(.XLEN(64), .REG_AW(5), .CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn),
        .dec_valid_i(dec_valid_i), .dec_ready_o(s_dec_ready),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .pc_i(pc_i), .imm_i(imm_i),
        .opr_a_sel_i(opr_a_sel_i), .opr_b_sel_i(opr_b_sel_i),
        .alu_func_i(alu_func_i), .rd_addr_i(rd_addr_i), .rd_wr_en_i(rd_wr_en_i),
        .ex_fwd_en_i(ex_fwd_en_i), .ex_fwd_rd_i(ex_fwd_rd_i),
        .ex_fwd_data_i(ex_fwd_data_i), .ex_fwd_pend_i(ex_fwd_pend_i),
        .wb_fwd_en_i(wb_fwd_en_i), .wb_fwd_rd_i(wb_fwd_rd_i), .wb_fwd_data_i(wb_fwd_data_i),
        .flush_i(flush_i),
        .ex_valid_o(s_ex_valid), .ex_ready_i(ex_ready_i),
        .opr_a_o(s_opr_a), .opr_b_o(s_opr_b), .alu_func_o(s_alu_func),
        .rd_addr_o(s_rd_addr), .rd_wr_en_o(s_rd_wr_en), .stall_cnt_o(s_stall_cnt)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  func;
        logic [4:0]  rd;
        logic        wr;
    } item_t;

    item_t       exp_q[$];
    int unsigned stall_m;
    bit          flushed_m;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] resolve(input logic [4:0] a, input logic [63:0] rf);
        if (a == 0) return 64'd0;
        if (ex_fwd_en_i && ex_fwd_rd_i == a) return ex_fwd_data_i;
        if (wb_fwd_en_i && wb_fwd_rd_i == a) return wb_fwd_data_i;
        return rf;
    endfunction

    function automatic bit waits_on_load(input logic [4:0] a);
        return (a != 0) && ex_fwd_en_i && ex_fwd_pend_i && (ex_fwd_rd_i == a);
    endfunction

    task automatic set_idle();
        dec_valid_i = 0; rs1_addr_i = 0; rs2_addr_i = 0; rs1_data_i = 0; rs2_data_i = 0;
        pc_i = 0; imm_i = 0; opr_a_sel_i = SEL_RS1; opr_b_sel_i = SEL_RS2;
        alu_func_i = OP_ADD; rd_addr_i = 0; rd_wr_en_i = 0;
        ex_fwd_en_i = 0; ex_fwd_rd_i = 0; ex_fwd_data_i = 0; ex_fwd_pend_i = 0;
        wb_fwd_en_i = 0; wb_fwd_rd_i = 0; wb_fwd_data_i = 0;
        flush_i = 0; ex_ready_i = 1;
    endtask

    // Advance one clock: the model predicts this edge from the current inputs.
    task automatic step();
        bit    free, stall, exp_ready;
        item_t it;
        @(negedge clk);
        #1;
        free      = (exp_q.size() == 0) || ex_ready_i;
        stall     = (opr_a_sel_i == SEL_RS1 && waits_on_load(rs1_addr_i)) ||
                    (opr_b_sel_i == SEL_RS2 && waits_on_load(rs2_addr_i));
        exp_ready = free && !stall && !flush_i;
        check("dec_ready", dec_ready_o, exp_ready);
        if (dec_valid_i && !exp_ready && !flush_i) stall_m++;
        if (flush_i) begin
            exp_q.delete();
            flushed_m = 1;
        end else if (dec_valid_i && exp_ready) begin
            it.a    = opr_a_sel_i ? pc_i  : resolve(rs1_addr_i, rs1_data_i);
            it.b    = opr_b_sel_i ? imm_i : resolve(rs2_addr_i, rs2_data_i);
            it.func = alu_func_i;
            it.rd   = rd_addr_i;
            it.wr   = rd_wr_en_i;
            exp_q.delete();
            exp_q.push_back(it);
            flushed_m = 0;
        end else if (free) begin
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the model every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn === 1'b1) begin
                check("ex_valid", ex_valid_o, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    check("opr_a", opr_a_o, exp_q[0].a);
                    check("opr_b", opr_b_o, exp_q[0].b);
                    check("alu_func", alu_func_o, exp_q[0].func);
                    check("rd_addr", rd_addr_o, exp_q[0].rd);
                    check("rd_wr_en", rd_wr_en_o, exp_q[0].wr);
                end else if (flushed_m) begin
                    check("rd_wr_en_flushed", rd_wr_en_o, 0);
                end
                check("stall_cnt", stall_cnt_o, stall_m);
                check("stall_cnt4", s_stall_cnt, (stall_m > 15) ? 15 : stall_m);
            end
        end
    end

    initial begin
        logic [63:0] held_a;
        set_idle();
        resetn = 0; stall_m = 0; flushed_m = 0;
        #3;
        check("rst_ex_valid", ex_valid_o, 0);
        check("rst_opr_a", opr_a_o, 0);
        check("rst_opr_b", opr_b_o, 0);
        check("rst_alu_func", alu_func_o, OP_ADD);
        check("rst_rd_wr_en", rd_wr_en_o, 0);
        check("rst_stall", stall_cnt_o, 0);
        #9 resetn = 1;
        @(posedge clk); #1;

        // Basic issue from the register file.
        dec_valid_i = 1; rs1_addr_i = 3; rs1_data_i = 5; rs2_addr_i = 4; rs2_data_i = 7;
        rd_addr_i = 9; rd_wr_en_i = 1;
        step();
        check("t1_valid", ex_valid_o, 1);
        check("t1_opr_a", opr_a_o, 5);
        check("t1_opr_b", opr_b_o, 7);

        // Forwarding priority and x0.
        ex_fwd_en_i = 1; ex_fwd_rd_i = 3; ex_fwd_data_i = 64'h10;
        wb_fwd_en_i = 1; wb_fwd_rd_i = 3; wb_fwd_data_i = 64'h20;
        step();
        check("fwd_ex", opr_a_o, 64'h10);
        ex_fwd_en_i = 0;
        step();
        check("fwd_wb", opr_a_o, 64'h20);
        rs1_addr_i = 0; ex_fwd_en_i = 1; ex_fwd_rd_i = 0; wb_fwd_rd_i = 0;
        step();
        check("fwd_x0", opr_a_o, 0);

        // Load-use hazard: bubble on RS1, no stall with PC selected.
        rs1_addr_i = 3; ex_fwd_rd_i = 3; ex_fwd_pend_i = 1; pc_i = 64'h1000;
        #1 check("haz_ready", dec_ready_o, 0);
        step();
        check("haz_bubble", ex_valid_o, 0);
        check("haz_stall1", stall_cnt_o, 1);
        opr_a_sel_i = SEL_PC;
        step();
        check("haz_pc_valid", ex_valid_o, 1);
        check("haz_pc_opr_a", opr_a_o, 64'h1000);
        ex_fwd_pend_i = 0; opr_a_sel_i = SEL_RS1;

        // Back-pressure for three cycles, then back-to-back accepts.
        held_a = opr_a_o;
        ex_ready_i = 0; pc_i = 64'h2000; opr_a_sel_i = SEL_PC;
        repeat (3) step();
        check("hold_opr_a", opr_a_o, held_a);
        check("hold_stall", stall_cnt_o, 4);
        ex_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            imm_i = 64'(i + 100); opr_b_sel_i = SEL_IMM;
            step();
            check("b2b_opr_b", opr_b_o, 64'(i + 100));
        end

        // Flush with a full slot and a pending decode.
        ex_ready_i = 0; flush_i = 1;
        step();
        check("flush_valid", ex_valid_o, 0);
        check("flush_wr_en", rd_wr_en_o, 0);
        check("flush_stall", stall_cnt_o, 4);
        flush_i = 0; ex_ready_i = 1;

        // Randomized traffic with small register indices to provoke matches.
        for (int n = 0; n < 400; n++) begin
            dec_valid_i   = ($urandom_range(0, 9) < 8);
            rs1_addr_i    = 5'($urandom_range(0, 3));
            rs2_addr_i    = 5'($urandom_range(0, 3));
            rs1_data_i    = {$urandom, $urandom};
            rs2_data_i    = {$urandom, $urandom};
            pc_i          = {$urandom, $urandom};
            imm_i         = {$urandom, $urandom};
            opr_a_sel_i   = $urandom_range(0, 3) == 0;
            opr_b_sel_i   = $urandom_range(0, 3) == 0;
            alu_func_i    = 4'($urandom_range(0, 9));
            rd_addr_i     = 5'($urandom);
            rd_wr_en_i    = 1'($urandom);
            ex_fwd_en_i   = 1'($urandom);
            ex_fwd_rd_i   = 5'($urandom_range(0, 3));
            ex_fwd_data_i = {$urandom, $urandom};
            ex_fwd_pend_i = $urandom_range(0, 3) == 0;
            wb_fwd_en_i   = 1'($urandom);
            wb_fwd_rd_i   = 5'($urandom_range(0, 3));
            wb_fwd_data_i = {$urandom, $urandom};
            flush_i       = $urandom_range(0, 9) == 0;
            ex_ready_i    = $urandom_range(0, 9) < 7;
            step();
        end

        // Long hold drives the narrow counter into saturation, then reset mid-hold.
        set_idle();
        dec_valid_i = 1; rd_wr_en_i = 1; alu_func_i = OP_XOR; pc_i = 64'hABCD; opr_a_sel_i = SEL_PC;
        step();
        ex_ready_i = 0;
        repeat (20) step();
        check("sat_cnt4", s_stall_cnt, 4'hF);
        check("sat_valid", ex_valid_o, 1);
        #2 resetn = 0;
        #2;
        check("mid_rst_valid", ex_valid_o, 0);
        check("mid_rst_opr_a", opr_a_o, 0);
        check("mid_rst_func", alu_func_o, OP_ADD);
        check("mid_rst_wr_en", rd_wr_en_o, 0);
        check("mid_rst_stall", stall_cnt_o, 0);
        check("mid_rst_stall4", s_stall_cnt, 0);
        exp_q.delete(); stall_m = 0; flushed_m = 0;
        set_idle();
        @(negedge clk); #2 resetn = 1;
        @(posedge clk); #1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
